// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder/subtractor with start/done handshake and overflow flag
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_param
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] s_ext;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [DIGIT+1:0] dig;

  // Ripple of DIGIT full-adder cells; returns {carry out, carry into top cell, sum digit}
  function automatic logic [DIGIT+1:0] add_digit(input logic [DIGIT-1:0] a,
                                                  input logic [DIGIT-1:0] b,
                                                  input logic             cin);
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[DIGIT], c[DIGIT-1], s};
  endfunction

  assign busy = (state == RUN);
  assign last = (cnt == CW'(N - 1));

  // Digit add of the current low operand digits, and the result with that digit inserted at the top
  always_comb begin
    s_ext              = '0;
    dig                = add_digit(a_sh[DIGIT-1:0], b_sh[DIGIT-1:0], carry);
    s_ext[DIGIT-1:0]   = dig[DIGIT-1:0];
    res_next           = (res >> DIGIT) | (s_ext << (WIDTH - DIGIT));
  end

  // Next-state: accept start only when idle, return to idle after the last digit
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand capture, digit shifting, and result/flag update on the completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sh  <= A;
          b_sh  <= sub ? ~B : B;
          carry <= sub ? 1'b1 : Cin;
          cnt   <= '0;
        end
      end else begin
        a_sh  <= a_sh >> DIGIT;
        b_sh  <= b_sh >> DIGIT;
        res   <= res_next;
        carry <= dig[DIGIT+1];
        cnt   <= cnt + CW'(1);
        if (last) begin
          Sum  <= res_next;
          Cout <= dig[DIGIT+1];
          Ovf  <= dig[DIGIT+1] ^ dig[DIGIT];
          done <= 1'b1;
        end
      end
    end
  end

endmodule
